// File: rtl/rx_intf_pkg.sv
// Shared definitions for the RX byte-to-word path: FSM encoding, word geometry,
// and the FCS/sequence-number field that can be stamped into the final word.
package rx_intf_pkg;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_PACK     = 2'd1;
  localparam logic [1:0] ST_WAIT_FCS = 2'd2;

  localparam int BYTES_PER_WORD   = 8;
  localparam int LANE_W           = 3;

  localparam int SN_FIELD_W       = 16;
  localparam int SN_FIELD_FCS_BIT = 15;
  localparam int SN_FIELD_SN_W    = 12;

  // Field is {fcs_ok, 3'b0, sn[11:0]}, stored little-endian over the FCS tail.
  function automatic logic [SN_FIELD_W-1:0] sn_field(input logic fcs_ok,
                                                     input logic [SN_FIELD_SN_W-1:0] sn);
    logic [SN_FIELD_W-1:0] f;
    f = '0;
    f[SN_FIELD_SN_W-1:0] = sn;
    f[SN_FIELD_FCS_BIT]  = fcs_ok;
    return f;
  endfunction

endpackage

// File: rtl/rx_byte_packer.sv
// Writes bytes into 8 lanes of a 64-bit word; o_word shows the word including this cycle's byte.
// Zero latency combinationally; no backpressure, lanes clear on i_clr.
module rx_byte_packer
  import rx_intf_pkg::*;
(
  input  logic                clk,
  input  logic                rstn,
  input  logic                i_clr,
  input  logic                i_wr,
  input  logic [LANE_W-1:0]   i_lane,
  input  logic [7:0]          i_byte,
  output logic [63:0]         o_word,
  output logic                o_full
);

  logic [63:0] r_lanes;
  logic [63:0] w_merged;

  always_comb begin
    w_merged = r_lanes;
    for (int i = 0; i < BYTES_PER_WORD; i++) begin
      if (i_wr && (i_lane == LANE_W'(i))) w_merged[i*8 +: 8] = i_byte;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)      r_lanes <= '0;
    else if (i_clr) r_lanes <= '0;
    else if (i_wr)  r_lanes <= w_merged;
  end

  assign o_word = w_merged;
  assign o_full = i_wr && (i_lane == LANE_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/rx_byte_to_word_fcs_sn_insert.sv
// Packs PSDU bytes into 64-bit words (1-cycle latency), holds the last word until the FCS verdict.
// No backpressure; RX_FCS_SN_INSERT_EN stamps {fcs_ok,3'b0,sn} over the FCS tail of the final word.
module rx_byte_to_word_fcs_sn_insert
  import rx_intf_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int LEN_WIDTH  = 16,
  parameter int SN_WIDTH   = 12
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  sig_valid,
  input  logic                  ht_unsupport,
  input  logic [LEN_WIDTH-1:0]  pkt_len,
  input  logic [7:0]            byte_in,
  input  logic                  byte_in_strobe,
  input  logic                  fcs_in_strobe,
  input  logic                  fcs_ok,
  input  logic                  rx_pkt_sn_plus_one,
  output logic [DATA_WIDTH-1:0] data_to_acc,
  output logic                  data_ready_to_acc,
  output logic                  fcs_valid,
  output logic [SN_WIDTH-1:0]   rx_pkt_sn,
  output logic                  byte_overrun
);

  logic [1:0]            r_state;
  logic [LEN_WIDTH-1:0]  r_len;
  logic [LEN_WIDTH-1:0]  r_idx;
  logic [SN_WIDTH-1:0]   r_sn;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_vld;
  logic                  r_fcs_valid;
  logic                  r_overrun;

  logic                  w_accept;
  logic                  w_wr;
  logic                  w_last;
  logic                  w_full;
  logic                  w_emit_mid;
  logic                  w_emit_final;
  logic                  w_clr;
  logic [LEN_WIDTH-1:0]  w_len_m1;
  logic [DATA_WIDTH-1:0] w_pk_word;
  logic [DATA_WIDTH-1:0] w_final_word;

  assign w_accept     = sig_valid && !ht_unsupport && (pkt_len != '0);
  assign w_len_m1     = r_len - LEN_WIDTH'(1);
  assign w_wr         = (r_state == ST_PACK) && byte_in_strobe && !w_accept;
  assign w_last       = (r_idx == w_len_m1);
  assign w_emit_mid   = w_full && !w_last;
  // The final word leaves either with its last byte (same-cycle verdict) or later from WAIT_FCS.
  assign w_emit_final = (w_wr && w_last && fcs_in_strobe) ||
                        ((r_state == ST_WAIT_FCS) && fcs_in_strobe && !w_accept);
  assign w_clr        = w_accept || w_emit_mid || w_emit_final;

  rx_byte_packer u_packer (
    .clk    (clk),
    .rstn   (rstn),
    .i_clr  (w_clr),
    .i_wr   (w_wr),
    .i_lane (r_idx[LANE_W-1:0]),
    .i_byte (byte_in),
    .o_word (w_pk_word),
    .o_full (w_full)
  );

`ifdef RX_FCS_SN_INSERT_EN
  logic [LANE_W-1:0]     w_last_lane;
  logic [SN_FIELD_W-1:0] w_field;

  assign w_last_lane = w_len_m1[LANE_W-1:0];
  assign w_field     = sn_field(fcs_ok, SN_FIELD_SN_W'(r_sn));

  // Low byte lands one lane below; when the tail straddles words only the high byte is here.
  always_comb begin
    w_final_word = w_pk_word;
    for (int i = 0; i < BYTES_PER_WORD; i++) begin
      if (w_last_lane == LANE_W'(i))
        w_final_word[i*8 +: 8] = w_field[15:8];
      else if ({1'b0, w_last_lane} == (LANE_W+1)'(i + 1))
        w_final_word[i*8 +: 8] = w_field[7:0];
    end
  end
`else
  assign w_final_word = w_pk_word;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
      r_len   <= '0;
      r_idx   <= '0;
    end else if (w_accept) begin
      r_state <= ST_PACK;
      r_len   <= pkt_len;
      r_idx   <= '0;
    end else begin
      case (r_state)
        ST_PACK: begin
          if (w_wr) begin
            r_idx <= r_idx + LEN_WIDTH'(1);
            if (w_last) r_state <= fcs_in_strobe ? ST_IDLE : ST_WAIT_FCS;
          end
        end
        ST_WAIT_FCS: if (fcs_in_strobe) r_state <= ST_IDLE;
        default:     r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_data      <= '0;
      r_vld       <= 1'b0;
      r_fcs_valid <= 1'b0;
    end else begin
      r_vld       <= w_emit_mid || w_emit_final;
      r_fcs_valid <= w_emit_final && fcs_ok;
      if (w_emit_mid)        r_data <= w_pk_word;
      else if (w_emit_final) r_data <= w_final_word;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_overrun <= 1'b0;
      r_sn      <= '0;
    end else begin
      if (w_accept)                                  r_overrun <= 1'b0;
      else if (byte_in_strobe && r_state != ST_PACK) r_overrun <= 1'b1;
      if (rx_pkt_sn_plus_one) r_sn <= r_sn + SN_WIDTH'(1);
    end
  end

  assign data_to_acc       = r_data;
  assign data_ready_to_acc = r_vld;
  assign fcs_valid         = r_fcs_valid;
  assign rx_pkt_sn         = r_sn;
  assign byte_overrun      = r_overrun;

endmodule

// File: tb/tb_rx_byte_to_word_fcs_sn_insert.sv
// Randomized bench for rx_byte_to_word_fcs_sn_insert with a byte-array reference model.
// Expected words come from slicing each packet's byte list and overwriting its FCS tail.
module tb_rx_byte_to_word_fcs_sn_insert;

  logic        clk = 1'b0;
  logic        rstn;
  logic        sig_valid, ht_unsupport, byte_in_strobe, fcs_in_strobe, fcs_ok, rx_pkt_sn_plus_one;
  logic [15:0] pkt_len;
  logic [7:0]  byte_in;
  logic [63:0] data_to_acc;
  logic        data_ready_to_acc, fcs_valid, byte_overrun;
  logic [11:0] rx_pkt_sn;

  int checks = 0;
  int errors = 0;
  int nwords = 0;

  logic [63:0] expq[$];
  logic        expf[$];
  logic [63:0] seen_w[$];
  logic        seen_f[$];
  logic [7:0]  pb[0:63];
  logic [7:0]  fb[0:63];
  logic [11:0] msn;
  int          base_cnt;

`ifdef RX_FCS_SN_INSERT_EN
  localparam logic [63:0] T1_W1 = 64'h8000_0D0C_0B0A_0908;
  localparam logic [63:0] T3_W1 = 64'h0000_0000_050A_0908;
`else
  localparam logic [63:0] T1_W1 = 64'h0F0E_0D0C_0B0A_0908;
  localparam logic [63:0] T3_W1 = 64'h0000_000C_0B0A_0908;
`endif

  always #5 clk = ~clk;

  rx_byte_to_word_fcs_sn_insert dut (
    .clk                (clk),
    .rstn               (rstn),
    .sig_valid          (sig_valid),
    .ht_unsupport       (ht_unsupport),
    .pkt_len            (pkt_len),
    .byte_in            (byte_in),
    .byte_in_strobe     (byte_in_strobe),
    .fcs_in_strobe      (fcs_in_strobe),
    .fcs_ok             (fcs_ok),
    .rx_pkt_sn_plus_one (rx_pkt_sn_plus_one),
    .data_to_acc        (data_to_acc),
    .data_ready_to_acc  (data_ready_to_acc),
    .fcs_valid          (fcs_valid),
    .rx_pkt_sn          (rx_pkt_sn),
    .byte_overrun       (byte_overrun)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rstn) begin
      if (fcs_valid) check_val("fcs_valid_without_word", 64'(fcs_valid), 64'(data_ready_to_acc));
      if (data_ready_to_acc) begin
        nwords++;
        seen_w.push_back(data_to_acc);
        seen_f.push_back(fcs_valid);
        if (expq.size() == 0) check_val("spurious_word", 64'(data_ready_to_acc), 64'd0);
        else begin
          check_val("word", data_to_acc, expq.pop_front());
          check_val("fcs_valid", 64'(fcs_valid), 64'(expf.pop_front()));
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] word_at(input int base, input int len, input bit use_fb);
    logic [63:0] w;
    w = '0;
    for (int j = 0; j < 8; j++)
      if (base + j < len) w[j*8 +: 8] = use_fb ? fb[base + j] : pb[base + j];
    return w;
  endfunction

  // Final word: overwrite bytes len-2 and len-1 with the status field, then slice.
  task automatic push_final(input int len, input logic ok, input logic [11:0] sn);
    logic [15:0] fld;
    for (int j = 0; j < 64; j++) fb[j] = pb[j];
`ifdef RX_FCS_SN_INSERT_EN
    fld = {ok, 3'b000, sn};
    fb[len-1] = fld[15:8];
    if (len >= 2) fb[len-2] = fld[7:0];
`else
    fld = 16'(sn);
`endif
    expq.push_back(word_at(((len - 1) / 8) * 8, len, 1'b1));
    expf.push_back(ok);
  endtask

  task automatic start(input int len, input logic ht);
    sig_valid = 1'b1; pkt_len = 16'(len); ht_unsupport = ht;
    tick;
    sig_valid = 1'b0; ht_unsupport = 1'b0;
  endtask

  task automatic pulse_sn(input int n);
    for (int k = 0; k < n; k++) begin
      rx_pkt_sn_plus_one = 1'b1; tick; rx_pkt_sn_plus_one = 1'b0;
      msn = msn + 12'd1;
    end
  endtask

  task automatic raw_bytes(input int n);
    for (int k = 0; k < n; k++) begin
      byte_in = 8'($urandom); byte_in_strobe = 1'b1; tick; byte_in_strobe = 1'b0;
    end
  endtask

  task automatic send_pkt(input int len, input logic ok, input bit same, input bit inc, input int gap);
    int nw;
    start(len, 1'b0);
    nw = (len + 7) / 8;
    for (int k = 0; k < nw - 1; k++) begin
      expq.push_back(word_at(k * 8, len, 1'b0));
      expf.push_back(1'b0);
    end
    for (int i = 0; i < len; i++) begin
      byte_in = pb[i]; byte_in_strobe = 1'b1;
      if (same && i == len - 1) begin
        fcs_in_strobe = 1'b1; fcs_ok = ok;
        push_final(len, ok, msn);
        if (inc) begin rx_pkt_sn_plus_one = 1'b1; msn = msn + 12'd1; end
      end
      tick;
      byte_in_strobe = 1'b0; fcs_in_strobe = 1'b0; rx_pkt_sn_plus_one = 1'b0;
      repeat ($urandom_range(0, 1)) tick;
    end
    if (!same) begin
      repeat (gap) tick;
      fcs_in_strobe = 1'b1; fcs_ok = ok;
      push_final(len, ok, msn);
      if (inc) begin rx_pkt_sn_plus_one = 1'b1; msn = msn + 12'd1; end
      tick;
      fcs_in_strobe = 1'b0; rx_pkt_sn_plus_one = 1'b0;
    end
    fcs_ok = 1'b0;
  endtask

  initial begin
    rstn = 1'b0; sig_valid = 1'b0; ht_unsupport = 1'b0; pkt_len = '0; byte_in = '0;
    byte_in_strobe = 1'b0; fcs_in_strobe = 1'b0; fcs_ok = 1'b0; rx_pkt_sn_plus_one = 1'b0;
    msn = '0;
    repeat (2) tick;
    check_val("rst_data", data_to_acc, 64'd0);
    check_val("rst_ready", 64'(data_ready_to_acc), 64'd0);
    check_val("rst_fcs_valid", 64'(fcs_valid), 64'd0);
    check_val("rst_sn", 64'(rx_pkt_sn), 64'd0);
    check_val("rst_overrun", 64'(byte_overrun), 64'd0);
    rstn = 1'b1;
    tick;

    // 16 bytes 0x00..0x0F, verdict with the last byte
    for (int i = 0; i < 16; i++) pb[i] = 8'(i);
    base_cnt = nwords;
    send_pkt(16, 1'b1, 1'b1, 1'b0, 0);
    repeat (2) tick;
    check_val("t1_count", 64'(nwords - base_cnt), 64'd2);
    check_val("t1_w0", seen_w[seen_w.size() - 2], 64'h0706_0504_0302_0100);
    check_val("t1_w1", seen_w[seen_w.size() - 1], T1_W1);
    check_val("t1_fcs_valid", 64'(seen_f[seen_f.size() - 1]), 64'd1);

    // Sequence counter wrap
    pulse_sn(4095);
    check_val("sn_max", 64'(rx_pkt_sn), 64'hFFF);
    pulse_sn(1);
    check_val("sn_wrap", 64'(rx_pkt_sn), 64'd0);

    // 13-byte packet, bad FCS, sn=5
    pulse_sn(5);
    for (int i = 0; i < 13; i++) pb[i] = 8'(i);
    base_cnt = nwords;
    send_pkt(13, 1'b0, 1'b0, 1'b0, 2);
    repeat (2) tick;
    check_val("t3_count", 64'(nwords - base_cnt), 64'd2);
    check_val("t3_w1", seen_w[seen_w.size() - 1], T3_W1);
    check_val("t3_fcs_valid", 64'(seen_f[seen_f.size() - 1]), 64'd0);

    // Unsupported header ignored, then a real 9-byte packet
    base_cnt = nwords;
    start(9, 1'b1);
    raw_bytes(9);
    repeat (2) tick;
    check_val("ht_no_words", 64'(nwords - base_cnt), 64'd0);
    check_val("ht_overrun", 64'(byte_overrun), 64'd1);
    for (int i = 0; i < 9; i++) pb[i] = 8'($urandom);
    send_pkt(9, 1'b1, 1'b0, 1'b0, 1);
    repeat (2) tick;
    check_val("len9_count", 64'(nwords - base_cnt), 64'd2);
    check_val("len9_overrun_clr", 64'(byte_overrun), 64'd0);

    // Abort after 5 of 16 bytes
    base_cnt = nwords;
    start(16, 1'b0);
    raw_bytes(5);
    for (int i = 0; i < 16; i++) pb[i] = 8'($urandom);
    send_pkt(16, 1'b1, 1'b0, 1'b0, 3);
    repeat (2) tick;
    check_val("abort_count", 64'(nwords - base_cnt), 64'd2);

    // Overrun after the final byte
    for (int i = 0; i < 10; i++) pb[i] = 8'($urandom);
    send_pkt(10, 1'b1, 1'b0, 1'b0, 0);
    repeat (2) tick;
    check_val("ovr_before", 64'(byte_overrun), 64'd0);
    base_cnt = nwords;
    raw_bytes(3);
    repeat (2) tick;
    check_val("ovr_set", 64'(byte_overrun), 64'd1);
    check_val("ovr_no_words", 64'(nwords - base_cnt), 64'd0);
    start(12, 1'b0);
    check_val("ovr_clear", 64'(byte_overrun), 64'd0);

    // Same-cycle sn increment with the verdict inserts the old sn
    for (int i = 0; i < 20; i++) pb[i] = 8'($urandom);
    send_pkt(20, 1'b1, 1'b1, 1'b1, 0);
    for (int i = 0; i < 22; i++) pb[i] = 8'($urandom);
    send_pkt(22, 1'b1, 1'b0, 1'b1, 2);
    repeat (2) tick;
    check_val("sn_after_inc", 64'(rx_pkt_sn), 64'(msn));

    // Random packets
    for (int p = 0; p < 30; p++) begin
      int len;
      len = $urandom_range(1, 40);
      for (int i = 0; i < len; i++) pb[i] = 8'($urandom);
      send_pkt(len, 1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 3));
      pulse_sn($urandom_range(0, 3));
      repeat ($urandom_range(0, 2)) tick;
    end
    repeat (3) tick;
    check_val("rand_sn", 64'(rx_pkt_sn), 64'(msn));
    check_val("rand_drain", 64'(expq.size()), 64'd0);

    // Asynchronous reset mid-PACK
    pulse_sn(1);
    start(16, 1'b0);
    raw_bytes(3);
    #2 rstn = 1'b0;
    #1;
    check_val("arst_sn", 64'(rx_pkt_sn), 64'd0);
    check_val("arst_ready", 64'(data_ready_to_acc), 64'd0);
    check_val("arst_data", data_to_acc, 64'd0);
    check_val("arst_overrun", 64'(byte_overrun), 64'd0);
    tick;
    rstn = 1'b1;
    msn = '0;
    base_cnt = nwords;
    raw_bytes(13);
    repeat (3) tick;
    check_val("arst_no_words", 64'(nwords - base_cnt), 64'd0);
    check_val("arst_idle_overrun", 64'(byte_overrun), 64'd1);
    for (int i = 0; i < 11; i++) pb[i] = 8'($urandom);
    send_pkt(11, 1'b1, 1'b0, 1'b0, 1);
    repeat (3) tick;
    check_val("final_drain", 64'(expq.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
